// File: rtl/btb_pkg.sv
// Shared definitions for the tagged branch target buffer.
package btb_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned TARGET_W = 32;
    localparam int unsigned KIND_W   = 2;
    localparam int unsigned CTR_W    = 2;

    // Branch kind as reported by execute on update.
    typedef enum logic [KIND_W-1:0] {
        KindNone     = 2'b00,
        KindDirect   = 2'b01,
        KindCond     = 2'b10,
        KindIndirect = 2'b11
    } btb_kind_e;

    // Two-bit saturating direction counter; bit 1 is the taken prediction.
    localparam logic [CTR_W-1:0] CTR_STRONG_NOT_TAKEN = 2'b00;
    localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN       = 2'b10;
    localparam logic [CTR_W-1:0] CTR_STRONG_TAKEN     = 2'b11;

    // Saturating counter step toward the resolved direction.
    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr,
                                                   input logic             taken);
        logic [CTR_W-1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_STRONG_TAKEN) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_STRONG_NOT_TAKEN) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tagged_btb_if.sv
// Fetch-side lookup and execute-side update signals of the BTB.
interface tagged_btb_if;

    logic        lookup_en;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_tpc;
    logic        upd_taken;
    logic [1:0]  upd_kind;
    logic        flush;

    modport master (
        output lookup_en, fetch_pc, upd_en, upd_pc, upd_tpc, upd_taken, upd_kind, flush,
        input  pred_valid, pred_taken, pred_pc
    );

    modport slave (
        input  lookup_en, fetch_pc, upd_en, upd_pc, upd_tpc, upd_taken, upd_kind, flush,
        output pred_valid, pred_taken, pred_pc
    );

endinterface

// File: rtl/btb_entry_ram.sv
// Entry storage (tag/target/kind/ctr): one asynchronous read port, one write port.
// A read in the same cycle as a write to the same index returns the old contents.
module btb_entry_ram
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned TAG_W = 12,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [TARGET_W-1:0] rd_target,
    output logic [KIND_W-1:0]   rd_kind,
    output logic [CTR_W-1:0]    rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [TARGET_W-1:0] wr_target,
    input  logic [KIND_W-1:0]   wr_kind,
    input  logic [CTR_W-1:0]    wr_ctr
);

    logic [TAG_W-1:0]    tag_mem    [DEPTH];
    logic [TARGET_W-1:0] target_mem [DEPTH];
    logic [KIND_W-1:0]   kind_mem   [DEPTH];
    logic [CTR_W-1:0]    ctr_mem    [DEPTH];

    // Write all fields of the addressed entry on the rising edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
            kind_mem[wr_idx]   <= wr_kind;
            ctr_mem[wr_idx]    <= wr_ctr;
        end
    end

    assign rd_tag    = tag_mem[rd_idx];
    assign rd_target = target_mem[rd_idx];
    assign rd_kind   = kind_mem[rd_idx];
    assign rd_ctr    = ctr_mem[rd_idx];

endmodule

// File: rtl/tagged_btb.sv
// Direct-mapped tagged BTB with 2-bit direction counters and registered prediction.
module tagged_btb
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned TAG_W  = 12,
    parameter int unsigned PC_LSB = 3
) (
    input  logic         clk,
    input  logic         rst,
    tagged_btb_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TAG_LSB = PC_LSB + IDX_W;

    logic [DEPTH-1:0] valid_q;

    logic [IDX_W-1:0]    l_idx,    u_idx;
    logic [TAG_W-1:0]    l_tag,    u_tag;
    logic [TAG_W-1:0]    l_rd_tag, u_rd_tag;
    logic [TARGET_W-1:0] l_rd_target, u_rd_target;
    logic [KIND_W-1:0]   l_rd_kind, u_rd_kind;
    logic [CTR_W-1:0]    l_rd_ctr, u_rd_ctr;

    logic                l_hit, l_taken, u_hit;
    logic [PC_W-1:0]     l_pc;

    logic                ram_we, set_valid, clr_valid;
    logic [TARGET_W-1:0] wr_target;
    logic [KIND_W-1:0]   wr_kind;
    logic [CTR_W-1:0]    wr_ctr;

    logic                pred_valid_q, pred_taken_q;
    logic [PC_W-1:0]     pred_pc_q;

    // Upper PC bits beyond the tag do not take part in matching.
    logic unused_upd_pc;
    assign unused_upd_pc = ^bus.upd_pc;

    assign l_idx = bus.fetch_pc[PC_LSB +: IDX_W];
    assign l_tag = bus.fetch_pc[TAG_LSB +: TAG_W];
    assign u_idx = bus.upd_pc[PC_LSB +: IDX_W];
    assign u_tag = bus.upd_pc[TAG_LSB +: TAG_W];

    // Storage is replicated so lookup and update each get a private read port;
    // both copies receive identical writes and so always hold the same contents.
    btb_entry_ram #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_ram_lookup (
        .clk       (clk),
        .rd_idx    (l_idx),
        .rd_tag    (l_rd_tag),
        .rd_target (l_rd_target),
        .rd_kind   (l_rd_kind),
        .rd_ctr    (l_rd_ctr),
        .wr_en     (ram_we),
        .wr_idx    (u_idx),
        .wr_tag    (u_tag),
        .wr_target (wr_target),
        .wr_kind   (wr_kind),
        .wr_ctr    (wr_ctr)
    );

    btb_entry_ram #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_ram_update (
        .clk       (clk),
        .rd_idx    (u_idx),
        .rd_tag    (u_rd_tag),
        .rd_target (u_rd_target),
        .rd_kind   (u_rd_kind),
        .rd_ctr    (u_rd_ctr),
        .wr_en     (ram_we),
        .wr_idx    (u_idx),
        .wr_tag    (u_tag),
        .wr_target (wr_target),
        .wr_kind   (wr_kind),
        .wr_ctr    (wr_ctr)
    );

    // Lookup prediction from pre-update contents; a same-cycle flush forces a miss.
    always_comb begin
        l_hit   = valid_q[l_idx] && (l_rd_tag == l_tag) && !bus.flush;
        l_taken = l_hit && ((l_rd_kind != KindCond) || l_rd_ctr[1]);
        l_pc    = l_taken ? l_rd_target : bus.fetch_pc + 32'd8;
    end

    // Update decode: train on hit, allocate on taken miss, drop under reset or flush.
    always_comb begin
        u_hit     = valid_q[u_idx] && (u_rd_tag == u_tag);
        ram_we    = 1'b0;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        wr_target = u_rd_target;
        wr_kind   = bus.upd_kind;
        wr_ctr    = u_rd_ctr;
        if (!rst && bus.upd_en && !bus.flush) begin
            if (u_hit) begin
                if (bus.upd_kind == KindNone) begin
                    clr_valid = 1'b1;
                end else begin
                    ram_we = 1'b1;
                    wr_ctr = ctr_next(u_rd_ctr, bus.upd_taken);
                    if (bus.upd_taken) wr_target = bus.upd_tpc;
                end
            end else if (bus.upd_taken && (bus.upd_kind != KindNone)) begin
                ram_we    = 1'b1;
                set_valid = 1'b1;
                wr_target = bus.upd_tpc;
                wr_ctr    = CTR_WEAK_TAKEN;
            end
        end
    end

    // Valid bits live in flops so reset and flush clear every entry in one edge.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[u_idx] <= 1'b1;
        end else if (clr_valid) begin
            valid_q[u_idx] <= 1'b0;
        end
    end

    // Prediction registers; hold their value while lookup_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
        end else if (bus.lookup_en) begin
            pred_valid_q <= l_hit;
            pred_taken_q <= l_taken;
            pred_pc_q    <= l_pc;
        end
    end

    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_taken_q;
    assign bus.pred_pc    = pred_pc_q;

endmodule

// File: tb/tb_tagged_btb.sv
// Directed self-checking bench for tagged_btb (DEPTH=64, TAG_W=12, PC_LSB=3).
module tb_tagged_btb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    tagged_btb_if bus_if ();

    tagged_btb #(.DEPTH(64), .TAG_W(12), .PC_LSB(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pred(input string tag, input logic v, input logic t,
                              input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, bus_if.pred_valid}, {31'd0, v});
        check({tag, ".taken"}, {31'd0, bus_if.pred_taken}, {31'd0, t});
        check({tag, ".pc"}, bus_if.pred_pc, pc);
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tpc,
                          input logic taken, input logic [1:0] kind);
        bus_if.upd_en    = 1'b1;
        bus_if.upd_pc    = pc;
        bus_if.upd_tpc   = tpc;
        bus_if.upd_taken = taken;
        bus_if.upd_kind  = kind;
        step();
        bus_if.upd_en    = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic v,
                          input logic t, input logic [31:0] epc);
        bus_if.lookup_en = 1'b1;
        bus_if.fetch_pc  = pc;
        step();
        bus_if.lookup_en = 1'b0;
        check_pred(tag, v, t, epc);
    endtask

    initial begin
        // Reset with a lookup and an install pending: reset must win over both.
        bus_if.lookup_en = 1'b1;
        bus_if.fetch_pc  = 32'h1000;
        bus_if.upd_en    = 1'b1;
        bus_if.upd_pc    = 32'h1000;
        bus_if.upd_tpc   = 32'h2000;
        bus_if.upd_taken = 1'b1;
        bus_if.upd_kind  = 2'b10;
        bus_if.flush     = 1'b0;
        step();
        step();
        check_pred("reset", 1'b0, 1'b0, 32'h0);
        rst              = 1'b0;
        bus_if.lookup_en = 1'b0;
        bus_if.upd_en    = 1'b0;

        lookup("first_miss", 32'h1000, 1'b0, 1'b0, 32'h1008);
        lookup("wrap", 32'hFFFF_FFF8, 1'b0, 1'b0, 32'h0000_0000);

        // Install conditional taken, ctr=10.
        update(32'h1000, 32'h2000, 1'b1, 2'b10);
        lookup("install", 32'h1000, 1'b1, 1'b1, 32'h2000);

        // Counter walks down 10 -> 01 -> 00.
        update(32'h1000, 32'h2000, 1'b0, 2'b10);
        lookup("ctr01", 32'h1000, 1'b1, 1'b0, 32'h1008);
        update(32'h1000, 32'h2000, 1'b0, 2'b10);
        lookup("ctr00", 32'h1000, 1'b1, 1'b0, 32'h1008);

        // Four taken updates: 01, 10, 11, 11; last one retargets.
        update(32'h1000, 32'h2000, 1'b1, 2'b10);
        lookup("up_ctr01", 32'h1000, 1'b1, 1'b0, 32'h1008);
        update(32'h1000, 32'h2000, 1'b1, 2'b10);
        update(32'h1000, 32'h2000, 1'b1, 2'b10);
        update(32'h1000, 32'h2400, 1'b1, 2'b10);
        lookup("sat11", 32'h1000, 1'b1, 1'b1, 32'h2400);
        // Saturated at 11: one not-taken stays taken, second goes not-taken.
        update(32'h1000, 32'h2000, 1'b0, 2'b10);
        lookup("sat_dn10", 32'h1000, 1'b1, 1'b1, 32'h2400);
        update(32'h1000, 32'h2000, 1'b0, 2'b10);
        lookup("sat_dn01", 32'h1000, 1'b1, 1'b0, 32'h1008);

        // Alias at same index, different tag.
        lookup("alias", 32'h1200, 1'b0, 1'b0, 32'h1208);
        update(32'h1000, 32'h0, 1'b0, 2'b00);
        lookup("kind00_clr", 32'h1000, 1'b0, 1'b0, 32'h1008);

        // Direct branch ignores the counter for direction.
        update(32'h3000, 32'h4000, 1'b1, 2'b01);
        update(32'h3000, 32'h5000, 1'b0, 2'b01);
        update(32'h3000, 32'h5000, 1'b0, 2'b01);
        lookup("direct", 32'h3000, 1'b1, 1'b1, 32'h4000);

        // Not-taken miss allocates nothing.
        update(32'h5008, 32'h6000, 1'b0, 2'b10);
        lookup("nt_miss", 32'h5008, 1'b0, 1'b0, 32'h5010);

        // Same-cycle lookup and install at 0x1000: old contents seen first.
        bus_if.lookup_en = 1'b1;
        bus_if.fetch_pc  = 32'h1000;
        update(32'h1000, 32'h2000, 1'b1, 2'b10);
        bus_if.lookup_en = 1'b0;
        check_pred("rbw_same", 1'b0, 1'b0, 32'h1008);
        lookup("rbw_next", 32'h1000, 1'b1, 1'b1, 32'h2000);
        lookup("evicted", 32'h3000, 1'b0, 1'b0, 32'h3008);

        // Indirect entry at a different index.
        update(32'h6010, 32'h7000, 1'b1, 2'b11);
        lookup("indirect", 32'h6010, 1'b1, 1'b1, 32'h7000);

        // Flush with a simultaneous update and lookup.
        bus_if.flush     = 1'b1;
        bus_if.lookup_en = 1'b1;
        bus_if.fetch_pc  = 32'h6010;
        update(32'h8008, 32'h9000, 1'b1, 2'b01);
        bus_if.flush     = 1'b0;
        bus_if.lookup_en = 1'b0;
        check_pred("flush_lookup", 1'b0, 1'b0, 32'h6018);
        lookup("flush_1000", 32'h1000, 1'b0, 1'b0, 32'h1008);
        lookup("flush_6010", 32'h6010, 1'b0, 1'b0, 32'h6018);
        lookup("flush_upd", 32'h8008, 1'b0, 1'b0, 32'h8010);

        // Hold: outputs frozen while lookup_en is low, even across an update.
        update(32'h1000, 32'h2000, 1'b1, 2'b10);
        lookup("hold_setup", 32'h1000, 1'b1, 1'b1, 32'h2000);
        bus_if.fetch_pc = 32'h9000;
        update(32'h1000, 32'h0, 1'b0, 2'b00);
        check_pred("hold1", 1'b1, 1'b1, 32'h2000);
        step();
        check_pred("hold2", 1'b1, 1'b1, 32'h2000);
        step();
        check_pred("hold3", 1'b1, 1'b1, 32'h2000);
        lookup("hold_after", 32'h1000, 1'b0, 1'b0, 32'h1008);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
